// File: rtl/ro_freq_uart_tx.sv
// ro_freq_uart_tx
// Dumps the packed ring-oscillator count bus over a UART line (8N1, idle high).
// On a dump request it holds the counter bank (pause) for two cycles and then
// snapshots the bus. It then sends a 0xA5 header, every 32-bit count big-endian
// (word 0 first), and finally an XOR checksum of all count bytes.
//
// Ports:
//   clk    in  : system clock, rising-edge logic
//   reset  in  : asynchronous, active-high reset
//   start  in  : dump request, honoured only while idle
//   freq   in  : NUM_COUNTERS packed 32-bit counts, word i at [32i+31:32i]
//   pause  out : freezes the counter bank output register during the snapshot
//   tx     out : UART line
//   busy   out : high while a dump is in progress
//   done   out : one-cycle pulse after the final stop bit
module ro_freq_uart_tx #(
  parameter int NUM_COUNTERS = 1,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [NUM_COUNTERS*32-1:0] freq,
  output logic                      pause,
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  localparam int NUM_BYTES = 4 * NUM_COUNTERS + 2;
  localparam int IDX_W     = $clog2(NUM_BYTES);
  localparam int BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [IDX_W-1:0]  CSUM_IDX  = IDX_W'(NUM_BYTES - 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]        HEADER    = 8'hA5;

  typedef enum logic [1:0] {IDLE, HOLD, SEND, FINISH} state_t;

  state_t                    state, state_nxt;
  logic                      hold_cnt;
  logic [BAUD_W-1:0]         baud_cnt;
  logic [3:0]                bit_cnt;
  logic [IDX_W-1:0]          byte_idx;
  logic [7:0]                cur_byte;
  logic [7:0]                checksum;
  logic [NUM_COUNTERS*32-1:0] shadow;

  logic tx_nxt, pause_nxt, busy_nxt, done_nxt;
  logic baud_end, byte_end, frame_end;
  logic [IDX_W+3:0] bit_ofs;
  logic [7:0]       count_byte;
  logic [7:0]       next_byte;

  assign baud_end  = (baud_cnt == BAUD_LAST);
  assign byte_end  = baud_end && (bit_cnt == 4'd9);
  assign frame_end = byte_end && (byte_idx == LAST_IDX);

  // While byte_idx is being sent, the next count byte to load has zero-based
  // offset byte_idx (the header occupies slot 0). Words go out big-endian, so
  // the lane within the word is 3 - byte_idx[1:0], i.e. its bitwise inverse.
  always_comb begin
    bit_ofs    = (IDX_W+4)'({byte_idx[IDX_W-1:2], 5'b0}) +
                 (IDX_W+4)'({~byte_idx[1:0], 3'b0});
    count_byte = 8'(shadow >> bit_ofs);
    next_byte  = (byte_idx == CSUM_IDX) ? checksum : count_byte;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = HOLD;
      HOLD:    if (hold_cnt)  state_nxt = SEND;
      SEND:    if (frame_end) state_nxt = FINISH;
      FINISH:                 state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; registering them keeps tx glitch-free
  always_comb begin
    tx_nxt    = tx;
    pause_nxt = pause;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt    = 1'b1;
        pause_nxt = start;
        busy_nxt  = start;
      end
      HOLD: begin
        if (hold_cnt) begin
          pause_nxt = 1'b0;
          tx_nxt    = 1'b0;
        end
      end
      SEND: begin
        if (baud_end) begin
          if (bit_cnt == 4'd9) begin
            tx_nxt   = frame_end;
            done_nxt = frame_end;
          end else if (bit_cnt == 4'd8) begin
            tx_nxt = 1'b1;
          end else begin
            tx_nxt = cur_byte[bit_cnt[2:0]];
          end
        end
      end
      FINISH: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
      default: begin
        tx_nxt    = 1'b1;
        pause_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx    <= 1'b1;
      pause <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      tx    <= tx_nxt;
      pause <= pause_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Datapath: hold timer, snapshot, baud/bit/byte counters and checksum.
  // The checksum picks up each count byte as it is loaded, so when the final
  // slot is reached it already covers every count byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      cur_byte <= '0;
      checksum <= '0;
      shadow   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) hold_cnt <= 1'b0;
        end
        HOLD: begin
          hold_cnt <= 1'b1;
          if (hold_cnt) begin
            shadow   <= freq;
            byte_idx <= '0;
            checksum <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            cur_byte <= HEADER;
          end
        end
        SEND: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (frame_end) begin
                byte_idx <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
                cur_byte <= next_byte;
                if (byte_idx != CSUM_IDX) checksum <= checksum ^ count_byte;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ro_freq_uart_tx.md
# ro_freq_uart_tx

Reads the packed per-oscillator frequency bus produced by the ring-oscillator counter bank and ships it off-chip as a framed UART byte stream. On a dump request it asserts `pause` to freeze the counter bank's output register, snapshots the bus into a shadow register, releases `pause`, then serializes a header, every 32-bit count and an XOR checksum. It sits between the RO counter array and the board UART pin, and is the host-facing read side of the measurement path.

## Interface
- `NUM_COUNTERS`, 1: number of 32-bit count words on `freq`; legal range 1..16.
- `CLKS_PER_BIT`, 868: `clk` cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `clk` in 1: system clock; all logic rises on its positive edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: dump request, sampled each edge; honoured only in IDLE.
- `freq` in NUM_COUNTERS*32: packed counts; word i at bits [32i+31:32i].
- `pause` out 1: high to hold the counter bank's output register stable.
- `tx` out 1: UART line, 8N1, idle high.
- `busy` out 1: high while a dump is in progress.
- `done` out 1: one-cycle pulse when the final stop bit completes.

## Operation
- States: IDLE, HOLD, SEND, FINISH.
- IDLE: `tx`=1, `pause`=0, `busy`=0. If `start`=1: `pause`<=1, `busy`<=1, HOLD counter <=0, go to HOLD.
- HOLD: lasts 2 cycles so that any `freq` update already launched has settled. On the second HOLD edge: shadow <= `freq`, `pause`<=0, byte index <=0, checksum <=0, start bit driven, go to SEND.
- Frame order: 0xA5 header; then word 0 .. word NUM_COUNTERS-1, each big-endian (bits 31:24 first); then checksum byte. Frame length is 4*NUM_COUNTERS+2 bytes.
- Checksum is the XOR of every count byte. The header is excluded.
- Each byte is sent as: start bit (0), data bits 0..7 (LSB first), stop bit (1). That is 10 bits, each exactly CLKS_PER_BIT cycles.
- Bytes are sent back to back; the next start bit immediately follows the previous stop bit.
- Bit counter, byte index and baud counter wrap to 0 at the end of their ranges. The baud counter is wide enough for CLKS_PER_BIT-1.
- Checksum accumulates a count byte when that byte is loaded for sending.
- When the checksum byte's stop bit ends: go to FINISH. FINISH is one cycle: `done`=1, `busy`<=0, go to IDLE.
- `start` in HOLD, SEND or FINISH is ignored, not queued.
- Changes on `freq` after the snapshot have no effect on the frame in flight.
- Reset, asynchronous and at any time including mid-byte: state IDLE, `tx`=1, `pause`=0, `busy`=0, `done`=0, shadow and checksum 0. No partial frame resumes.

## Timing
- Reset values: `tx`=1, `pause`=0, `busy`=0, `done`=0.
- Let edge k sample `start`=1 in IDLE.
- `pause`=1 and `busy`=1 from k to k+2. `pause` is therefore high for exactly 2 cycles.
- Edge k+2: snapshot is taken, `pause`=0, and `tx` falls (start bit of the header).
- Frame occupies 10*(4*NUM_COUNTERS+2)*CLKS_PER_BIT cycles starting at edge k+2.
- `done` pulses in the cycle following the frame; `busy` falls on the same edge that `done` falls.
- A new `start` is accepted on the edge after `done` at the earliest.
- All outputs are registered; `tx` is glitch-free.

## Test plan
- Reset: assert `reset` mid-byte with NUM_COUNTERS=2, CLKS_PER_BIT=4 -> `tx`=1, `pause`=0, `busy`=0 immediately (asynchronously). The next `start` produces a complete, fresh frame.
- Basic frame: NUM_COUNTERS=2, CLKS_PER_BIT=4, `freq`={32'h000186A0, 32'h00000010}, pulse `start` -> UART monitor decodes A5 00 00 00 10 00 01 86 A0 37. Frame lasts 400 cycles from the start-bit edge; one `done` pulse follows.
- Pause window: same stimulus -> `pause` high for exactly 2 cycles starting at the `start` edge, and low for the whole serialization.
- Snapshot isolation: change `freq` to all 0xFFFFFFFF one cycle after `pause` falls -> transmitted bytes and checksum still match the pre-change values.
- Start while busy: pulse `start` mid-frame -> it is ignored and only one frame/`done` results. A `start` on the edge after `done` begins a second frame with the correct 2-cycle `pause`.
- Single counter, default baud: NUM_COUNTERS=1, CLKS_PER_BIT=868, `freq`=32'hDEADBEEF -> A5 DE AD BE EF 22. Every bit lasts 868 cycles; the frame totals 52080 cycles.
